// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared register, with a clear that outranks writes.
// Define REG_ARB_PRIO0_EN to give requester 0 fixed top priority.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_req,
  output logic                      clr_ack,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      reg_load,
  output logic [DATA_W-1:0]         reg_data,
  output logic                      reg_sync_rst,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] next_ptr;
  logic            win_found;
  logic            prio_hit;

  // First valid requester scanning upward from rr_ptr, wrapping.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    prio_hit  = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
`ifdef REG_ARB_PRIO0_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_id    = '0;
      prio_hit  = 1'b1;
    end
`endif
  end

  assign next_ptr = (int'(win_id) == NUM_REQ - 1) ? '0
                  : win_id + ID_W'(1);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      reg_load     <= 1'b0;
      reg_data     <= '0;
      reg_sync_rst <= 1'b0;
      clr_ack      <= 1'b0;
      req_ready    <= '0;
      grant_id     <= '0;
    end else begin
      state        <= IDLE;
      reg_load     <= 1'b0;
      reg_data     <= '0;
      reg_sync_rst <= 1'b0;
      clr_ack      <= 1'b0;
      req_ready    <= '0;
      grant_id     <= '0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state        <= CLEAR;
            reg_sync_rst <= 1'b1;
            clr_ack      <= 1'b1;
          end else if (win_found) begin
            state     <= LOAD;
            reg_load  <= 1'b1;
            reg_data  <= req_data[int'(win_id)*DATA_W +: DATA_W];
            req_ready <= NUM_REQ'(1) << win_id;
            grant_id  <= win_id;
            if (!prio_hit) rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected ops queued at stimulus,
// popped and compared whenever the arbiter issues a LOAD or CLEAR.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        clr_ack;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        reg_load;
  logic [7:0]  reg_data;
  logic        reg_sync_rst;
  logic [1:0]  grant_id;
  logic        busy;

  reg_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .clr_req      (clr_req),
    .clr_ack      (clr_ack),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .reg_load     (reg_load),
    .reg_data     (reg_data),
    .reg_sync_rst (reg_sync_rst),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt[4];
  logic scramble = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic clr, input logic [1:0] id,
                      input logic [7:0] data);
    exp_t e;
    e.clr  = clr;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (reg_load || reg_sync_rst) begin
        if (sb.size() == 0) begin
          check("unexpected_op", 32'(reg_load), 32'(reg_sync_rst));
          check("unexpected_op_any", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("clr_kind", 32'(reg_sync_rst), 32'(e.clr));
          check("clr_ack", 32'(clr_ack), 32'(e.clr));
          check("load", 32'(reg_load), 32'(!e.clr));
          check("busy", 32'(busy), 32'd1);
          if (!e.clr) begin
            check("grant_id", 32'(grant_id), 32'(e.id));
            check("reg_data", 32'(reg_data), 32'(e.data));
            check("req_ready", 32'(req_ready), 32'(4'b0001 << e.id));
          end else begin
            check("ready_in_clr", 32'(req_ready), 32'd0);
          end
        end
      end else begin
        check("quiet", {req_ready, clr_ack, grant_id}, 32'd0);
      end
    end
  end

  // Requesters drop valid after their last word's ready pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        cnt[i]--;
        if (cnt[i] <= 0) req_valid[i] = 1'b0;
        if (scramble) req_data[i*8 +: 8] = 8'hFF;
      end
    end
    if (clr_ack) clr_req = 1'b0;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || |req_valid || clr_req)
           && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
    check("queue_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    clr_req   = 1'b0;
    scramble  = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input int n, input logic [7:0] d);
    cnt[i] = n;
    req_data[i*8 +: 8] = d;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_outs",
          {reg_load, reg_sync_rst, clr_ack, busy, req_ready, grant_id,
           reg_data}, 32'd0);

    // T1: reset mid-LOAD, then pointer must restart at 0
    set_req(1, 1, 8'h77);
    tick();
    check("t1_load_seen", 32'(reg_load), 32'd1);
    rst = 1'b1;
    #1;
    check("t1_async_outs",
          {reg_load, reg_sync_rst, clr_ack, busy, req_ready, grant_id,
           reg_data}, 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    push(1'b0, 2'd0, 8'hC0);
    push(1'b0, 2'd2, 8'hC2);
    set_req(0, 1, 8'hC0);
    set_req(2, 1, 8'hC2);
    run(40);

    // T2: single write, one-cycle latency to LOAD
    do_reset();
    push(1'b0, 2'd2, 8'hAA);
    set_req(2, 1, 8'hAA);
    tick();
    check("t2_latency", 32'(reg_load), 32'd1);
    run(20);

    // T3: all valid, round-robin order
    do_reset();
`ifdef REG_ARB_PRIO0_EN
    push(1'b0, 2'd0, 8'h10);
    push(1'b0, 2'd0, 8'h10);
    push(1'b0, 2'd1, 8'h11);
    push(1'b0, 2'd2, 8'h12);
    push(1'b0, 2'd3, 8'h13);
`else
    push(1'b0, 2'd0, 8'h10);
    push(1'b0, 2'd1, 8'h11);
    push(1'b0, 2'd2, 8'h12);
    push(1'b0, 2'd3, 8'h13);
    push(1'b0, 2'd0, 8'h10);
`endif
    set_req(0, 2, 8'h10);
    set_req(1, 1, 8'h11);
    set_req(2, 1, 8'h12);
    set_req(3, 1, 8'h13);
    run(60);

    // T4: clear outranks a simultaneous write
    do_reset();
    push(1'b1, 2'd0, 8'h00);
    push(1'b0, 2'd0, 8'h5A);
    clr_req = 1'b1;
    set_req(0, 1, 8'h5A);
    run(30);

    // T5: data/valid changes during LOAD are ignored
    do_reset();
    scramble = 1'b1;
    push(1'b0, 2'd1, 8'h55);
    set_req(1, 1, 8'h55);
    run(20);
    check("t5_data_scrambled", 32'(req_data[15:8]), 32'hFF);
    scramble = 1'b0;

    // T6: valid 1011 held
    do_reset();
`ifdef REG_ARB_PRIO0_EN
    push(1'b0, 2'd0, 8'h30);
    push(1'b0, 2'd0, 8'h30);
    push(1'b0, 2'd1, 8'h31);
    push(1'b0, 2'd3, 8'h33);
`else
    push(1'b0, 2'd0, 8'h30);
    push(1'b0, 2'd1, 8'h31);
    push(1'b0, 2'd3, 8'h33);
    push(1'b0, 2'd0, 8'h30);
`endif
    set_req(0, 2, 8'h30);
    set_req(1, 1, 8'h31);
    set_req(3, 1, 8'h33);
    run(60);

    // Held clear: CLEAR, IDLE, CLEAR with writes starved
    do_reset();
    push(1'b1, 2'd0, 8'h00);
    push(1'b1, 2'd0, 8'h00);
    push(1'b0, 2'd2, 8'h9C);
    clr_req = 1'b1;
    set_req(2, 1, 8'h9C);
    tick();
    tick();
    clr_req = 1'b1;
    run(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
